// File: rtl/m68k_bus_target_if.sv
// 68000 bus bundle between the PiStorm CPLD bus master and a bus target.
// master: drives address, data, strobes, function code and VMA_n.
// slave : returns read data, drive enable and the DTACK_n/VPA_n/BERR_n responses.
interface m68k_bus_target_if;
    logic [23:1] M68K_A;
    logic [15:0] M68K_D_IN;
    logic [15:0] M68K_D_OUT;
    logic        M68K_D_OE;
    logic [2:0]  M68K_FC;
    logic        M68K_AS_n;
    logic        M68K_UDS_n;
    logic        M68K_LDS_n;
    logic        M68K_RW;
    logic        M68K_VMA_n;
    logic        M68K_DTACK_n;
    logic        M68K_VPA_n;
    logic        M68K_BERR_n;

    modport master (
        output M68K_A, M68K_D_IN, M68K_FC, M68K_AS_n, M68K_UDS_n, M68K_LDS_n,
               M68K_RW, M68K_VMA_n,
        input  M68K_D_OUT, M68K_D_OE, M68K_DTACK_n, M68K_VPA_n, M68K_BERR_n
    );

    modport slave (
        input  M68K_A, M68K_D_IN, M68K_FC, M68K_AS_n, M68K_UDS_n, M68K_LDS_n,
               M68K_RW, M68K_VMA_n,
        output M68K_D_OUT, M68K_D_OE, M68K_DTACK_n, M68K_VPA_n, M68K_BERR_n
    );
endinterface

// File: rtl/m68k_bus_target.sv
// 68000 bus target: answers PiStorm bus-master cycles from a 256-word RAM
// window with DTACK_n, from the VPA region / IACK cycles with VPA_n.
// All 68k strobes are sampled on PI_CLK through 2-FF synchronisers.
// Optional feature macro M68K_TARGET_BERR_EN: unmapped or timed-out cycles get
// BERR_n; without it unmapped cycles are left unanswered and BERR_n is tied high.
module m68k_bus_target #(
    parameter logic [23:0] BASE_ADDR    = 24'hE80000,
    parameter int unsigned WAIT_CLKS    = 4,
    parameter logic [23:0] VPA_BASE     = 24'hBFE000,
    parameter int unsigned TIMEOUT_CLKS = 255
) (
    input  logic                    PI_CLK,
    input  logic                    RST,
    m68k_bus_target_if.slave        bus,
    output logic [15:0]             HIT_COUNT
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_VPA     = 3'd4;
`ifdef M68K_TARGET_BERR_EN
    localparam logic [2:0] S_ERR     = 3'd5;
`endif
    localparam logic [2:0] S_RELEASE = 3'd6;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CLKS);

    logic [2:0]  state;
    logic [1:0]  as_sync, uds_sync, lds_sync, vma_sync;
    logic [3:0]  wait_cnt;
    logic [8:1]  addr_q;
    logic [15:0] data_q;
    logic        rw_q;
    logic        iack_q;
    logic        ram_cyc;
    logic [15:0] d_out;
    logic        d_oe;
    logic [15:0] hit_count;
    logic [15:0] ram [256];

    // Address classification works on the byte address, widened so the window
    // end cannot wrap at the top of the 16 MB space.
    logic [24:0] byte_addr;
    logic        ram_hit, vpa_hit, iack;
    logic        as_low2, abort, wait_done, ram_we;
    logic [8:1]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] iack_vec;

    assign byte_addr = {1'b0, bus.M68K_A, 1'b0};
    assign ram_hit   = (byte_addr >= {1'b0, BASE_ADDR}) &&
                       (byte_addr <  ({1'b0, BASE_ADDR} + 25'd512));
    assign vpa_hit   = (byte_addr >= {1'b0, VPA_BASE}) &&
                       (byte_addr <  ({1'b0, VPA_BASE} + 25'd4096));
    assign iack      = (bus.M68K_FC == 3'b111);

    // Both synchroniser stages low = AS_n seen low on two consecutive samples.
    assign as_low2   = (as_sync == 2'b00);
    // Synced AS_n high ends any active cycle, completed or not.
    assign abort     = as_sync[1] && (state != S_IDLE) && (state != S_RELEASE);
    assign wait_done = (state == S_WAIT) && ram_cyc && (wait_cnt == 4'd0);
    assign ram_we    = wait_done && !abort && !rw_q;

    // A zero-wait read has to fetch in DECODE, before addr_q is captured.
    assign rd_addr   = (state == S_DECODE) ? bus.M68K_A[8:1] : addr_q;
    assign rd_data   = ram[rd_addr];
    assign iack_vec  = {8'h00, 8'h18 + {5'b0, addr_q[3:1]}};

    // Two-flop synchronisers for the asynchronous 68k strobes.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge PI_CLK or posedge RST) begin
        if (RST) begin
            as_sync  <= 2'b11;
            uds_sync <= 2'b11;
            lds_sync <= 2'b11;
            vma_sync <= 2'b11;
        end else begin
            as_sync  <= {as_sync[0],  bus.M68K_AS_n};
            uds_sync <= {uds_sync[0], bus.M68K_UDS_n};
            lds_sync <= {lds_sync[0], bus.M68K_LDS_n};
            vma_sync <= {vma_sync[0], bus.M68K_VMA_n};
        end
    end

`ifdef M68K_TARGET_BERR_EN
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CLKS);
    logic [15:0] tmo_cnt;

    // Timeout counter: loaded in DECODE, runs while a cycle awaits its answer.
    always_ff @(posedge PI_CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt <= 16'd0;
        end else if (state == S_DECODE) begin
            tmo_cnt <= TMO_LOAD;
        end else if (((state == S_WAIT) || ((state == S_VPA) && vma_sync[1])) &&
                     (tmo_cnt != 16'd0)) begin
            tmo_cnt <= tmo_cnt - 16'd1;
        end
    end
`endif

    // Cycle sequencer: decode, wait states, response, release and hit counting.
    always_ff @(posedge PI_CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            addr_q    <= '0;
            data_q    <= 16'd0;
            rw_q      <= 1'b1;
            iack_q    <= 1'b0;
            ram_cyc   <= 1'b0;
            d_out     <= 16'd0;
            d_oe      <= 1'b0;
            hit_count <= 16'd0;
        end else if (abort) begin
            state <= S_RELEASE;
            d_oe  <= 1'b0;
            if (((state == S_ACK) || (state == S_VPA)) && (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (as_low2)
                        state <= S_DECODE;
                end
                S_DECODE: begin
                    addr_q   <= bus.M68K_A[8:1];
                    data_q   <= bus.M68K_D_IN;
                    rw_q     <= bus.M68K_RW;
                    iack_q   <= iack;
                    ram_cyc  <= ram_hit;
                    wait_cnt <= WAIT_LOAD;
                    if (ram_hit) begin
                        state <= S_WAIT;
                        if ((WAIT_LOAD == 4'd0) && bus.M68K_RW) begin
                            d_out <= rd_data;
                            d_oe  <= 1'b1;
                        end
                    end else if (iack || vpa_hit) begin
                        state <= S_VPA;
                    end else begin
`ifdef M68K_TARGET_BERR_EN
                        state <= S_ERR;
`else
                        state <= S_WAIT;
`endif
                    end
                end
                S_WAIT: begin
                    if (wait_done) begin
                        state <= S_ACK;
                    end
`ifdef M68K_TARGET_BERR_EN
                    else if (tmo_cnt == 16'd0) begin
                        state <= S_ERR;
                        d_oe  <= 1'b0;
                    end
`endif
                    else if (ram_cyc) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        // Read data goes out one clock ahead of DTACK_n for setup.
                        if ((wait_cnt == 4'd1) && rw_q) begin
                            d_out <= rd_data;
                            d_oe  <= 1'b1;
                        end
                    end
                end
                S_VPA: begin
                    if (!vma_sync[1]) begin
                        if (rw_q) begin
                            d_out <= iack_q ? iack_vec : 16'h0000;
                            d_oe  <= 1'b1;
                        end
                    end
`ifdef M68K_TARGET_BERR_EN
                    else if (tmo_cnt == 16'd0) begin
                        state <= S_ERR;
                        d_oe  <= 1'b0;
                    end
`endif
                end
                S_ACK: ;
`ifdef M68K_TARGET_BERR_EN
                S_ERR: ;
`endif
                S_RELEASE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // RAM write on entry to ACK, byte lanes gated by the synced data strobes.
    // NOTE: the RAM array is deliberately not reset; contents survive RST.
    always_ff @(posedge PI_CLK) begin
        if (ram_we) begin
            if (!uds_sync[1])
                ram[addr_q][15:8] <= data_q[15:8];
            if (!lds_sync[1])
                ram[addr_q][7:0]  <= data_q[7:0];
        end
    end

    assign bus.M68K_DTACK_n = (state != S_ACK);
    assign bus.M68K_VPA_n   = (state != S_VPA);
`ifdef M68K_TARGET_BERR_EN
    assign bus.M68K_BERR_n  = (state != S_ERR);
`else
    assign bus.M68K_BERR_n  = 1'b1;
`endif
    assign bus.M68K_D_OUT   = d_out;
    assign bus.M68K_D_OE    = d_oe;
    assign HIT_COUNT        = hit_count;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Directed bench for m68k_bus_target: table of RAM bus cycles plus
// hand-written IACK/VPA, unmapped, aborted-cycle and mid-cycle reset sequences.
module tb_m68k_bus_target;

    localparam logic [23:0] BASE    = 24'hE80000;
    localparam int          WAITC   = 4;
    localparam logic [23:0] VPAB    = 24'hBFE000;
    // sync(2) + qualify(1) + DECODE(1) + wait states + ACK(1)
    localparam int          EXP_LAT = 2 + 1 + 1 + WAITC + 1;
    // sync(2) + qualify(1) + DECODE(1)
    localparam int          EXP_RSP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hit_count;

    always #5 clk = ~clk;

    m68k_bus_target_if bus();

    m68k_bus_target #(
        .BASE_ADDR   (BASE),
        .WAIT_CLKS   (WAITC),
        .VPA_BASE    (VPAB),
        .TIMEOUT_CLKS(255)
    ) dut (
        .PI_CLK   (clk),
        .RST      (rst),
        .bus      (bus),
        .HIT_COUNT(hit_count)
    );

    typedef struct {
        logic [23:0] addr;
        logic        rw;
        logic        uds_n;
        logic        lds_n;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[14];
    int   total = 0;
    int   bad   = 0;
    int   exp_hits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic sig_low(input int sel);
        case (sel)
            0:       return bus.M68K_DTACK_n == 1'b0;
            1:       return bus.M68K_VPA_n == 1'b0;
            default: return bus.M68K_BERR_n == 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] resp();
        return {bus.M68K_DTACK_n, bus.M68K_VPA_n, bus.M68K_BERR_n, bus.M68K_D_OE};
    endfunction

    task automatic bus_idle();
        bus.M68K_AS_n  = 1'b1;
        bus.M68K_UDS_n = 1'b1;
        bus.M68K_LDS_n = 1'b1;
        bus.M68K_RW    = 1'b1;
        bus.M68K_VMA_n = 1'b1;
        bus.M68K_FC    = 3'b101;
        bus.M68K_A     = '0;
        bus.M68K_D_IN  = 16'h0000;
    endtask

    task automatic start_cycle(input logic [23:0] a, input logic [2:0] fc, input logic rw,
                               input logic uds_n, input logic lds_n, input logic [15:0] d);
        bus.M68K_A     = a[23:1];
        bus.M68K_FC    = fc;
        bus.M68K_RW    = rw;
        bus.M68K_D_IN  = d;
        bus.M68K_UDS_n = uds_n;
        bus.M68K_LDS_n = lds_n;
        bus.M68K_AS_n  = 1'b0;
    endtask

    // Counts falling edges until the selected response is seen low (99 = never).
    task automatic wait_low(input int sel, output int lat, output logic poe);
        logic seen;
        logic prev;
        seen = 1'b0;
        lat  = 99;
        poe  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (!seen) begin
                prev = bus.M68K_D_OE;
                @(negedge clk);
                if (sig_low(sel)) begin
                    seen = 1'b1;
                    lat  = i;
                    poe  = prev;
                end
            end
        end
    endtask

    task automatic end_cycle(input string nm);
        bus_idle();
        repeat (3) @(negedge clk);
        check({nm, " released"}, resp(), 4'b1110);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int   lat;
        logic poe;
        start_cycle(v.addr, 3'b101, v.rw, v.uds_n, v.lds_n, v.wdata);
        wait_low(0, lat, poe);
        check({nm, " dtack latency"}, lat, EXP_LAT);
        if (v.rw) begin
            check({nm, " read data"}, bus.M68K_D_OUT, v.rdata);
            check({nm, " data setup oe"}, poe, 1'b1);
        end else begin
            check({nm, " write oe"}, {poe, bus.M68K_D_OE}, 2'b00);
        end
        end_cycle(nm);
        exp_hits++;
        check({nm, " hit count"}, hit_count, exp_hits);
    endtask

    task automatic unmapped(input logic [23:0] a, input int n, input string nm);
        int   lat;
        logic poe;
        logic any;
        start_cycle(a, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000);
`ifdef M68K_TARGET_BERR_EN
        wait_low(2, lat, poe);
        check({nm, " berr latency"}, lat, EXP_RSP);
        check({nm, " berr response"}, resp(), 4'b1100);
        any = poe;
`else
        lat = n;
        any = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (resp() != 4'b1110) any = 1'b1;
        end
        check({nm, " no response"}, any, 1'b0);
`endif
        end_cycle(nm);
        check({nm, " hit count"}, hit_count, exp_hits);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic poe;
        logic any;

        vecs[0]  = '{24'hE80002, 1'b0, 1'b0, 1'b0, 16'hA55A, 16'h0000};
        vecs[1]  = '{24'hE80002, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hA55A};
        vecs[2]  = '{24'hE80004, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000};
        vecs[3]  = '{24'hE80004, 1'b0, 1'b0, 1'b1, 16'h3C77, 16'h0000};
        vecs[4]  = '{24'hE80004, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h3CFF};
        vecs[5]  = '{24'hE80006, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000};
        vecs[6]  = '{24'hE80006, 1'b0, 1'b1, 1'b0, 16'h9912, 16'h0000};
        vecs[7]  = '{24'hE80006, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFF12};
        vecs[8]  = '{24'hE801FE, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000};
        vecs[9]  = '{24'hE801FE, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234};
        vecs[10] = '{24'hE80000, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        vecs[11] = '{24'hE80000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF};
        vecs[12] = '{24'hE80002, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000};
        vecs[13] = '{24'hE80002, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hA55A};

        rst = 1'b1;
        bus_idle();
        repeat (3) @(negedge clk);
        check("reset responses", resp(), 4'b1110);
        check("reset d_out", bus.M68K_D_OUT, 16'h0000);
        check("reset hit count", hit_count, 16'h0000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // IACK autovector: A[3:1]=5 -> vector 0x1D
        start_cycle(24'hFFFFFA, 3'b111, 1'b1, 1'b1, 1'b0, 16'h0000);
        wait_low(1, lat, poe);
        check("iack vpa latency", lat, EXP_RSP);
        check("iack before vma", resp(), 4'b1010);
        bus.M68K_VMA_n = 1'b0;
        repeat (3) @(negedge clk);
        check("iack vector", bus.M68K_D_OUT, 16'h001D);
        check("iack after vma", resp(), 4'b1011);
        end_cycle("iack");
        exp_hits++;
        check("iack hit count", hit_count, exp_hits);

        // Last word of the VPA region
        start_cycle(VPAB + 24'h000FFE, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000);
        wait_low(1, lat, poe);
        check("vpa region latency", lat, EXP_RSP);
        bus.M68K_VMA_n = 1'b0;
        repeat (3) @(negedge clk);
        check("vpa region hold", bus.M68K_VPA_n, 1'b0);
        end_cycle("vpa region");
        exp_hits++;
        check("vpa region hit count", hit_count, exp_hits);

        // Just outside each mapped region, then address zero
        unmapped(24'hE80200, 30, "above window");
        unmapped(24'hE7FFFE, 30, "below window");
        unmapped(VPAB + 24'h001000, 30, "above vpa");
        unmapped(24'h000000, 1000, "addr zero");

        // Aborted write during WAIT: no ack, no write, no count
        start_cycle(24'hE80002, 3'b101, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (4) @(negedge clk);
        bus_idle();
        any = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.M68K_DTACK_n == 1'b0) any = 1'b1;
        end
        check("abort no dtack", any, 1'b0);
        check("abort hit count", hit_count, exp_hits);
        run_vec(vecs[13], "abort readback");

        // Reset while DTACK_n is asserted on a read
        start_cycle(24'hE80004, 3'b101, 1'b1, 1'b0, 1'b0, 16'h0000);
        wait_low(0, lat, poe);
        check("rst dtack seen", lat, EXP_LAT);
        #2 rst = 1'b1;
        #1 check("rst drops responses", resp(), 4'b1110);
        check("rst clears hit count", hit_count, 16'h0000);
        #1 rst = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        exp_hits = 0;
        run_vec(vecs[4], "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
